// File: rtl/riscv_issue_scoreboard_if.sv
// Issue-stage bundle: decode->issue instruction stream, issue->execute output register,
// long-latency writeback release, flush and busy status.
interface riscv_issue_scoreboard_if;
    // Valid/ready: a word moves on any posedge where valid and ready are both 1.
    // The sender holds valid and its payload stable until that edge, and ready
    // never waits on a later valid.
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_illegal;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        busy;

    modport master (
        output in_valid, in_inst, out_ready, wb_valid, wb_rd, flush,
        input  in_ready, out_valid, out_inst, out_illegal, busy
    );

    modport slave (
        input  in_valid, in_inst, out_ready, wb_valid, wb_rd, flush,
        output in_ready, out_valid, out_inst, out_illegal, busy
    );
endinterface

// File: rtl/riscv_issue_scoreboard.sv
// Issue scoreboard: decodes RV32 words, blocks RAW/WAW hazards against pending long-latency
// destinations, limits ops in flight. Define SCOREBOARD_STALL_CNT_EN to add a stall-cycle counter.
module riscv_issue_scoreboard #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
`ifdef SCOREBOARD_STALL_CNT_EN
    output logic [31:0]           stall_cycles,
`endif
    riscv_issue_scoreboard_if.slave sb,
    output logic                  dbg_state_o,
    output logic [31:0]           dbg_pending_o,
    output logic [CNT_W-1:0]      dbg_count_o
);

    localparam logic [6:0] OP_R       = 7'b0110011;
    localparam logic [6:0] OP_I       = 7'b0010011;
    localparam logic [6:0] OP_L       = 7'b0000011;
    localparam logic [6:0] OP_S       = 7'b0100011;
    localparam logic [6:0] OP_B       = 7'b1100011;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;

    localparam logic [CNT_W:0] MAX_CNT = MAX_OUTSTANDING[CNT_W:0];

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q;
    logic [31:0]      out_inst_q;
    logic             out_illegal_q;
    logic [31:0]      pending_q, pending_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;
    logic       uses_rs1, uses_rs2, writes_rd, long_op, illegal;

    assign opcode = sb.in_inst[6:0];
    assign rd     = sb.in_inst[11:7];
    assign funct3 = sb.in_inst[14:12];
    assign rs1    = sb.in_inst[19:15];
    assign rs2    = sb.in_inst[24:20];

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        long_op   = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_R: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_I, OP_JALR: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_L: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                long_op   = 1'b1;
                illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OP_CUSTOM0: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
                long_op   = 1'b1;
            end
            OP_S: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                illegal  = (funct3 > 3'b010);
            end
            OP_B: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    // A writeback in the same cycle already frees its register for the word being decoded.
    logic [31:0]    wb_mask, eff_pending;
    logic           hazard, limit, long_lat, lim_rel, rel_wb, slot_free, in_ready, accept;
    logic [CNT_W:0] cnt_after_rel;

    assign wb_mask     = sb.wb_valid ? (32'd1 << sb.wb_rd) : 32'd0;
    assign eff_pending = pending_q & ~wb_mask;
    assign long_lat    = long_op & ~illegal;
    assign hazard      = ~illegal & ((uses_rs1 & eff_pending[rs1]) |
                                     (uses_rs2 & eff_pending[rs2]) |
                                     (writes_rd & eff_pending[rd]));

    assign lim_rel       = sb.wb_valid & pending_q[sb.wb_rd];
    assign cnt_after_rel = {1'b0, count_q} - {{CNT_W{1'b0}}, lim_rel};
    assign limit         = long_lat & (cnt_after_rel == MAX_CNT);

    // rd=0 long ops live only in the count, so a wb_rd=0 completion releases one of those.
    assign rel_wb = sb.wb_valid & (count_q != '0) &
                    ((sb.wb_rd != 5'd0) ? pending_q[sb.wb_rd] : 1'b1);

    assign slot_free = (state_q == EMPTY) | sb.out_ready;
    assign in_ready  = resetn & slot_free & ~hazard & ~limit & ~sb.flush;
    assign accept    = sb.in_valid & in_ready;

    always_comb begin
        pending_d = pending_q;
        if (sb.wb_valid) pending_d[sb.wb_rd] = 1'b0;
        if (accept && long_lat && (rd != 5'd0)) pending_d[rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        count_d = count_q;
        if ((accept & long_lat) & ~rel_wb)      count_d = count_q + 1'b1;
        else if (~(accept & long_lat) & rel_wb) count_d = count_q - 1'b1;
    end

    // Flush only empties the output register; in-flight loads still write back.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= EMPTY;
            out_inst_q    <= '0;
            out_illegal_q <= 1'b0;
            pending_q     <= '0;
            count_q       <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
            if (sb.flush) begin
                state_q <= EMPTY;
            end else if (accept) begin
                state_q       <= FULL;
                out_inst_q    <= sb.in_inst;
                out_illegal_q <= illegal;
            end else if (sb.out_ready) begin
                state_q <= EMPTY;
            end
        end
    end

`ifdef SCOREBOARD_STALL_CNT_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_q <= '0;
        end else if (sb.in_valid && !in_ready && !sb.flush && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end
    assign stall_cycles = stall_q;
`endif

    assign sb.in_ready    = in_ready;
    assign sb.out_valid   = (state_q == FULL);
    assign sb.out_inst    = out_inst_q;
    assign sb.out_illegal = out_illegal_q;
    assign sb.busy        = resetn & (count_q != '0);

    assign dbg_state_o   = state_q;
    assign dbg_pending_o = pending_q;
    assign dbg_count_o   = count_q;

endmodule
